// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed driver for NUM_DIGITS common-anode 7-segment
// digits. Shows one of NUM_CH hex channels, latched once per frame so a frame
// never mixes two values. Also supports freeze, leading-zero blanking and a
// dash pattern for an out-of-range channel selection.
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int NUM_CH     = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int SEL_W      = 2
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [NUM_CH*NUM_DIGITS*4-1:0] ChanData,
  input  logic [SEL_W-1:0]               ChanSel,
  input  logic                           Freeze,
  input  logic                           BlankLZ,
  output logic [6:0]                     out7,
  output logic [NUM_DIGITS-1:0]          en_out,
  output logic                           FrameStart
);

  localparam int DW = NUM_DIGITS * 4;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_DARK = 7'b1111111;
  localparam logic [6:0]    SEG_DASH = 7'b1111110;

  // S_DARK covers the first prescaler period after reset, where nothing is lit.
  typedef enum logic {S_DARK, S_SCAN} scan_state_t;

  scan_state_t       state;
  logic [PW-1:0]     prescaler;
  logic [IW-1:0]     idx;
  logic [DW-1:0]     snapshot;
  logic [SEL_W-1:0]  sel_q;

  logic              tick;
  logic [DW-1:0]     chan_slice;
  logic              sel_valid;
  logic [3:0]        nibble;
  logic              digit_lz;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic              zero_run;
  logic [6:0]        seg_next;
  logic [NUM_DIGITS-1:0] en_next;

  // Active-low abcdefg pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b0000001;
      4'h1:    decode = 7'b1001111;
      4'h2:    decode = 7'b0010010;
      4'h3:    decode = 7'b0000110;
      4'h4:    decode = 7'b1001100;
      4'h5:    decode = 7'b0100100;
      4'h6:    decode = 7'b0100000;
      4'h7:    decode = 7'b0001111;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0000100;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b1100000;
      4'hC:    decode = 7'b0110001;
      4'hD:    decode = 7'b1000010;
      4'hE:    decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  assign tick = (prescaler == PRE_LAST);

  // Pick the live channel slice that a frame boundary would load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    chan_slice = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ChanSel == SEL_W'(k)) chan_slice = ChanData[k*DW +: DW];
    end
  end

  // Registered selection is valid only if it names an existing channel.
  always_comb begin
    sel_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == SEL_W'(k)) sel_valid = 1'b1;
    end
  end

  // lz_mask[i] is set when snapshot nibbles NUM_DIGITS-1..i are all zero; digit 0 never blanks.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (snapshot[i*4 +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
    lz_mask[0] = 1'b0;
  end

  // Current digit's nibble and blanking flag.
  always_comb begin
    nibble   = 4'h0;
    digit_lz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble   = snapshot[i*4 +: 4];
        digit_lz = lz_mask[i];
      end
    end
  end

  // Segment pattern and enable vector for the current digit.
  always_comb begin
    seg_next = decode(nibble);
    if (!sel_valid)               seg_next = SEG_DASH;
    else if (BlankLZ && digit_lz) seg_next = SEG_DARK;
    en_next = ~(NUM_DIGITS'(1) << idx);
  end

  // Scan control: prescaler, digit index, frame-boundary snapshot and selection.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state      <= S_DARK;
      prescaler  <= '0;
      idx        <= '0;
      // NOTE: the snapshot is a plain register, not a memory, so it is reset like any other state.
      snapshot   <= '0;
      sel_q      <= '0;
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= 1'b0;
      prescaler  <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        if (state == S_DARK) begin
          state <= S_SCAN;
        end else if (idx == IDX_LAST) begin
          idx        <= '0;
          FrameStart <= 1'b1;
          if (!Freeze) begin
            sel_q    <= ChanSel;
            snapshot <= chan_slice;
          end
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  // Output register: dark until the first digit period starts, then follows idx by one cycle.
  always_ff @(posedge Clk) begin
    if (Reset || state == S_DARK) begin
      out7   <= SEG_DARK;
      en_out <= '1;
    end else begin
      out7   <= seg_next;
      en_out <= en_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Testbench for seg7_scan_mux with 4 digits, 2 channels, 4-cycle digit period.
// A timing/arithmetic reference model predicts every output cycle.
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int NC = 2;
  localparam int SD = 4;
  localparam int SW = 2;
  localparam int FRAME = SD * ND;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC*ND*4-1:0] chan_data = '0;
  logic [SW-1:0]     chan_sel = '0;
  logic              freeze = 1'b0;
  logic              blank_lz = 1'b0;
  logic [6:0]        out7;
  logic [ND-1:0]     en_out;
  logic              frame_start;

  int tests = 0;
  int fails = 0;

  seg7_scan_mux #(
    .NUM_DIGITS(ND), .NUM_CH(NC), .SCAN_DIV(SD), .SEL_W(SW)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .ChanData  (chan_data),
    .ChanSel   (chan_sel),
    .Freeze    (freeze),
    .BlankLZ   (blank_lz),
    .out7      (out7),
    .en_out    (en_out),
    .FrameStart(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16];
  logic [3:0] en_seq  [4];
  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    en_seq  = '{4'hE, 4'hD, 4'hB, 4'h7};
  end

  // Reference model: t counts edges since reset release; the display timing
  // follows from t by arithmetic, the snapshot from the spec's load rules.
  int          t = 0;
  int unsigned m_snap = 0;
  int          m_sel = 0;
  logic [6:0]  exp_out7 = 7'h7F;
  logic [3:0]  exp_en = 4'hF;
  logic        exp_fs = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_snap = 0; m_sel = 0;
      exp_out7 = 7'h7F; exp_en = 4'hF; exp_fs = 1'b0;
    end else begin
      t = t + 1;
      exp_fs = (t > SD) && ((t - SD) % FRAME == 0);
      if (t <= SD) begin
        exp_out7 = 7'h7F; exp_en = 4'hF;
      end else begin
        int d;
        d = ((t - SD - 1) / SD) % ND;
        exp_en = ~(4'b0001 << d);
        if (m_sel >= NC) exp_out7 = 7'b1111110;
        else if (blank_lz && d != 0 && (m_snap >> (4 * d)) == 0) exp_out7 = 7'h7F;
        else exp_out7 = seg_tab[(m_snap >> (4 * d)) & 32'hF];
      end
      if (exp_fs && !freeze) begin
        m_sel  = int'(chan_sel);
        m_snap = (m_sel < NC) ? 32'(chan_data[m_sel*16 +: 16]) : 0;
      end
    end
  end

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (out7 !== 7'h7F || en_out !== 4'hF || frame_start !== 1'b0) begin
        fails++;
        $display("FAIL reset_dark: out7=%b en=%b fs=%b expected out7=1111111 en=1111 fs=0", out7, en_out, frame_start);
      end
    end
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); n++;
      if (en_out !== 4'hF) break;
    end
    tests++;
    if (n != SD + 1 || en_out !== 4'hE) begin
      fails++;
      $display("FAIL first_lit: cycles=%0d en=%b expected cycles=%0d en=1110", n, en_out, SD + 1);
    end
    for (int k = 0; k < 40; k++) begin
      if (frame_start === 1'b1) break;
      @(negedge clk); n++;
    end
    tests++;
    if (n != SD + FRAME || frame_start !== 1'b1) begin
      fails++;
      $display("FAIL first_frame: cycles=%0d fs=%b expected cycles=%0d fs=1", n, frame_start, SD + FRAME);
    end
  endtask

  task automatic test_hex_frame;
    bit ok;
    logic [6:0] segs [4];
    segs = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
    chan_data[15:0] = 16'h12AF; chan_sel = 2'd0;
    wait_frame(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL hex_frame_timeout: fs=%b expected fs=1", frame_start); end
    for (int s = 0; s < FRAME; s++) begin
      @(negedge clk);
      tests++;
      if (en_out !== en_seq[s/SD] || out7 !== segs[s/SD]) begin
        fails++;
        $display("FAIL hex_frame s=%0d: out7=%b en=%b expected out7=%b en=%b", s, out7, en_out, segs[s/SD], en_seq[s/SD]);
      end
    end
  endtask

  task automatic test_chansel_switch;
    logic [6:0] exp_seg;
    chan_data[31:16] = 16'h0005;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 6) begin chan_sel = 2'd1; blank_lz = 1'b1; end
      tests++;
      if ({out7, en_out, frame_start} !== {exp_out7, exp_en, exp_fs}) begin
        fails++;
        $display("FAIL chansel_model t=%0d: out7=%b en=%b fs=%b expected out7=%b en=%b fs=%b", t, out7, en_out, frame_start, exp_out7, exp_en, exp_fs);
      end
      if (n > 6 && frame_start === 1'b1) break;
    end
    for (int s = 0; s < FRAME; s++) begin
      @(negedge clk);
      exp_seg = (s / SD == 0) ? 7'b0100100 : 7'b1111111;
      tests++;
      if (en_out !== en_seq[s/SD] || out7 !== exp_seg) begin
        fails++;
        $display("FAIL chansel_blank s=%0d: out7=%b en=%b expected out7=%b en=%b", s, out7, en_out, exp_seg, en_seq[s/SD]);
      end
    end
  endtask

  task automatic test_freeze;
    bit ok;
    blank_lz = 1'b0; chan_sel = 2'd0;
    wait_frame(ok);
    freeze = 1'b1; chan_data[15:0] = 16'hFFFF;
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge clk);
      tests++;
      if ({out7, en_out, frame_start} !== {exp_out7, exp_en, exp_fs}
          || (en_out === 4'hB && out7 !== 7'b0010010)) begin
        fails++;
        $display("FAIL freeze_hold t=%0d: out7=%b en=%b fs=%b expected out7=%b en=%b fs=%b", t, out7, en_out, frame_start, exp_out7, exp_en, exp_fs);
      end
    end
    freeze = 1'b0;
    wait_frame(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL freeze_timeout: fs=%b expected fs=1", frame_start); end
    for (int s = 0; s < FRAME; s++) begin
      @(negedge clk);
      tests++;
      if (en_out !== en_seq[s/SD] || out7 !== 7'b0111000) begin
        fails++;
        $display("FAIL freeze_release s=%0d: out7=%b en=%b expected out7=0111000 en=%b", s, out7, en_out, en_seq[s/SD]);
      end
    end
  endtask

  task automatic test_invalid_channel;
    bit ok;
    chan_sel = 2'd3; blank_lz = 1'b1;
    wait_frame(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL invalid_timeout: fs=%b expected fs=1", frame_start); end
    for (int s = 0; s < FRAME; s++) begin
      @(negedge clk);
      tests++;
      if (en_out !== en_seq[s/SD] || out7 !== 7'b1111110) begin
        fails++;
        $display("FAIL invalid_dash s=%0d: out7=%b en=%b expected out7=1111110 en=%b", s, out7, en_out, en_seq[s/SD]);
      end
    end
    chan_sel = 2'd0; blank_lz = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      tests++;
      if ({out7, en_out, frame_start} !== {exp_out7, exp_en, exp_fs}) begin
        fails++;
        $display("FAIL invalid_restore t=%0d: out7=%b en=%b fs=%b expected out7=%b en=%b fs=%b", t, out7, en_out, frame_start, exp_out7, exp_en, exp_fs);
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    int n;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (en_out === 4'hB) break;
    end
    tests++;
    if (en_out !== 4'hB) begin fails++; $display("FAIL reset_mid_wait: en=%b expected en=1011", en_out); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (out7 !== 7'h7F || en_out !== 4'hF || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_dark: out7=%b en=%b fs=%b expected out7=1111111 en=1111 fs=0", out7, en_out, frame_start);
    end
    n = 0;
    repeat (SD + 1) begin @(negedge clk); n++; end
    tests++;
    if (en_out !== 4'hE || out7 !== 7'b0000001) begin
      fails++;
      $display("FAIL reset_mid_cleared: out7=%b en=%b expected out7=0000001 en=1110", out7, en_out);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      tests++;
      if ({out7, en_out, frame_start} !== {exp_out7, exp_en, exp_fs}) begin
        fails++;
        $display("FAIL reset_mid_model t=%0d: out7=%b en=%b fs=%b expected out7=%b en=%b fs=%b", t, out7, en_out, frame_start, exp_out7, exp_en, exp_fs);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      chan_data[15:0]  = 16'($urandom) >> $urandom_range(0, 16);
      chan_data[31:16] = 16'($urandom) >> $urandom_range(0, 16);
      chan_sel = SW'($urandom_range(0, 3));
      freeze   = ($urandom_range(0, 3) == 0);
      blank_lz = 1'($urandom_range(0, 1));
      repeat ($urandom_range(5, 30)) begin
        @(negedge clk);
        tests++;
        if ({out7, en_out, frame_start} !== {exp_out7, exp_en, exp_fs}) begin
          fails++;
          $display("FAIL random it=%0d t=%0d: out7=%b en=%b fs=%b expected out7=%b en=%b fs=%b", it, t, out7, en_out, frame_start, exp_out7, exp_en, exp_fs);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_frame();
    test_chansel_switch();
    test_freeze();
    test_invalid_channel();
    test_reset_mid_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
